// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution path: the 4-bit alucontrol
// encoding (so the decoder and the execution unit agree on one table), the
// execution FSM state type, and small helpers that classify shift codes.
// -----------------------------------------------------------------------------
package alu_pkg;

  // lui places the 16-bit immediate in the upper half of a 32-bit word.
  localparam int LUI_SHIFT = 16;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_LUI  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_BLEZ = 4'b1010,
    ALU_SRLV = 4'b1011,
    ALU_SRL  = 4'b1100,
    ALU_SLLV = 4'b1101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SLLV) || (op == ALU_SRLV);
  endfunction

  function automatic logic is_left_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SLLV);
  endfunction

  // sll/srl take the instruction's constant shamt; sllv/srlv take srca.
  function automatic logic uses_const_shamt(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_if
// Operation/result handshake bundle of the ALU execution unit.
//   request : in_valid, in_ready, alucontrol, srca, srcb, shamt
//   response: out_valid, out_ready, result, zero, illegal
// modport master : the issuing stage (drives the request, consumes result)
// modport slave  : the execution unit
// -----------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alucontrol, srca, srcb, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alucontrol, srca, srcb, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

endinterface

// File: rtl/alu_simple_core.sv
// -----------------------------------------------------------------------------
// alu_simple_core
// Purely combinational evaluation of every non-shift operation and the
// illegal-code flag. Shift codes are legal here but yield 0; the enclosing
// unit computes shifts itself.
// Ports:
//   op      in   alucontrol code
//   a, b    in   operands
//   result  out  operation result (0 for shift and illegal codes)
//   illegal out  code is not in the encoding table
// -----------------------------------------------------------------------------
module alu_simple_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:  result = a ^ b;
      ALU_LUI:  result = b << LUI_SHIFT;
      // a <= 0 as a signed value: negative, or exactly zero.
      ALU_BLEZ: result = {{(WIDTH-1){1'b0}}, (a[WIDTH-1] | (a == '0))};
      ALU_SLL, ALU_SRL, ALU_SLLV, ALU_SRLV: result = '0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Executes one alucontrol operation per valid/ready handshake and holds the
// result, zero flag and illegal flag until the downstream stage accepts them.
// Non-shift ops finish in one clock. Shifts move one bit per clock through
// the SHIFT state, unless ALU_BARREL_SHIFT_EN is defined, in which case they
// are computed combinationally and finish in one clock as well.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of alu_exec_unit_if (request + response handshake)
// Build option: `define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  alu_state_t       state;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [3:0]       op;
  logic             shift_op;
  logic             shift_left;
  logic [SHW-1:0]   shift_amt;
  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic [WIDTH-1:0] direct_result;

  assign op         = bus.alucontrol;
  assign shift_op   = is_shift_op(op);
  assign shift_left = is_left_shift(op);
  assign shift_amt  = uses_const_shamt(op) ? bus.shamt : bus.srca[SHW-1:0];

  alu_simple_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (bus.srca),
    .b       (bus.srcb),
    .result  (core_result),
    .illegal (core_illegal)
  );

  // Result for ops that complete straight out of IDLE.
`ifdef ALU_BARREL_SHIFT_EN
  always_comb begin
    direct_result = core_result;
    if (shift_op)
      direct_result = shift_left ? (bus.srcb << shift_amt) : (bus.srcb >> shift_amt);
  end
`else
  // Only zero-amount shifts leave IDLE directly, and they return b unchanged.
  always_comb begin
    direct_result = core_result;
    if (shift_op)
      direct_result = bus.srcb;
  end

  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             acc_left;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc_left ? (acc << 1) : (acc >> 1);
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
      acc         <= '0;
      cnt         <= '0;
      acc_left    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            if (shift_op && (shift_amt != '0)) begin
              state    <= SHIFT;
              acc      <= bus.srcb;
              cnt      <= shift_amt;
              acc_left <= shift_left;
            end else
`endif
            begin
              state       <= DONE;
              result_q    <= direct_result;
              zero_q      <= (direct_result == '0);
              illegal_q   <= core_illegal;
              out_valid_q <= 1'b1;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          // cnt==1 means this clock applies the last bit of the shift.
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            result_q    <= acc_next;
            zero_q      <= (acc_next == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution-side consumer of the 4-bit alucontrol code produced by the ALU decoder in the multicycle MIPS datapath. It accepts one operation per valid/ready handshake and computes single-cycle ops in one clock. Shifts iterate one bit per clock unless the barrel-shift option is compiled in. The result is held, with a zero flag, until the downstream stage accepts it.

Parameters:
WIDTH, 32, datapath width in bits; must be 32 for LUI semantics.
SHW, 5, shift-amount width, equal to log2(WIDTH).

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation
alucontrol  input  4  operation code (encoding below)
srca  input  WIDTH  operand A; srca[SHW-1:0] is the variable shift amount
srcb  input  WIDTH  operand B; the value that is shifted
shamt  input  SHW  constant shift amount (sll/srl)
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
illegal  output  1  accepted code was not in the encoding table

Behaviour:
- Codes:
  - 0000 and: a&b
  - 0001 or: a|b
  - 0010 add: a+b, wrap modulo 2^32, no overflow trap
  - 0110 sub: a-b, wrap
  - 0111 slt: {31'b0, $signed(a)<$signed(b)}
  - 1001 xor: a^b
  - 1000 lui: b<<16
  - 1010 blez: {31'b0, $signed(a)<=0}
  - 0011 sll: b<<shamt
  - 1100 srl: b>>shamt, logical
  - 1101 sllv: b<<a[4:0]
  - 1011 srlv: b>>a[4:0], logical
- Any other code, including X-free unlisted values: result=0, illegal=1, single-cycle latency.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and code.
    - Non-shift op → DONE.
    - Shift with amount 0 → DONE with result=b.
    - Otherwise → SHIFT, with cnt=amount and acc=b.
  - SHIFT: each clock, acc shifts one bit (left or right, zero fill) and cnt decrements. At cnt==1 the final shift is applied → DONE.
  - DONE: out_valid=1. When out_ready=1, → IDLE.
- Latency, with the handshake in cycle N:
  - Non-shift and zero-amount shifts: out_valid in cycle N+1.
  - Shift by k>0: out_valid in cycle N+1+k. Maximum N+32 for k=31.
- in_ready=0 in SHIFT and DONE. Inputs are ignored while not IDLE.
- No accept-while-draining. Throughput is one op per two cycles minimum.
- result, zero and illegal are registered and stable for the whole DONE period. They change only on entry to DONE.
- out_valid held with out_ready=0: all outputs stay frozen indefinitely.
- Reset, in any state including mid-shift: state=IDLE, result=0, zero=1, illegal=0, out_valid=0, in_ready=1 in the cycle after reset.
  - The in-flight op is discarded and no output is produced.
  - An in_valid during reset is ignored.

Optional Feature:
Macro ALU_BARREL_SHIFT_EN.
- Defined: all shifts are computed combinationally in IDLE and go directly to DONE. Every op has latency N+1, and the SHIFT state and counter are not synthesised.
- Undefined: iterative shifting as above.
- Functional results are identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_t with the 12 named codes above
  - typedef enum logic [1:0] alu_state_t {IDLE, SHIFT, DONE}
  - localparam LUI_SHIFT=16
- Decoder and execution unit both import alu_op_t so the encoding lives in one place.
- Sub-module alu_simple_core: purely combinational non-shift ops plus the illegal flag. alu_exec_unit instantiates it and owns the FSM, shift counter and output registers.

Test Plan:
- Reset, then add 0x7FFFFFFF+0x00000001 with out_ready=1 → out_valid at N+1, result=0x80000000, zero=0, illegal=0.
- sub 5-5 → result=0, zero=1. Then slt 0xFFFFFFFF vs 0x00000001 → result=1.
- sll b=0x00000001, shamt=31 → result=0x80000000 at N+32 (iterative) or N+1 (ALU_BARREL_SHIFT_EN). in_ready=0 throughout.
- srlv a=0x00000024 (amount 4), b=0xF0000000 → result=0x0F000000 at N+5. Then sllv with amount 0 → result=b at N+1.
- lui b=0x00001234 → 0x12340000. blez a=0 → 1. Code 1111 → result=0, illegal=1.
- Backpressure: hold out_ready=0 for 10 cycles → outputs frozen and in_ready=0. Assert reset mid-SHIFT → in_ready=1 and out_valid=0 the next cycle, and no stale result appears.
